// File: rtl/pool_seq_pkg.sv
// Shared types and helpers for the pooling-layer sequencer.
package pool_seq_pkg;

    // Layer sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        STREAM,
        DRAIN,
        FIN
    } state_t;

    // Cycles the pooling datapath is held in reset before each channel.
    localparam int FLUSH_CYC = 2;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int safe_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_layer_sequencer_addr_gen.sv
// Column/row/stripe walker with an incremental read-address accumulator.
// rd_addr is the address of the next read; last flags the final read of a channel.
module pool_addr_gen
    import pool_seq_pkg::*;
#(
    parameter int M      = 4,
    parameter int P      = 2,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              master_rst,
    input  logic              step,
    input  logic              clear_ch,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] row_stride,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              last
);

    localparam int COL_W = safe_w(M);
    localparam int ROW_W = safe_w(P);
    localparam int STR_W = safe_w(M / P);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(M - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(P - 1);
    localparam logic [STR_W-1:0] STR_LAST = STR_W'(M / P - 1);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [STR_W-1:0]  stripe;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] cur_addr;

    // Advance the nested counters and the address on every issued read.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge master_rst) begin
        if (master_rst) begin
            col      <= '0;
            row      <= '0;
            stripe   <= '0;
            row_base <= '0;
            cur_addr <= '0;
        end else if (clear_ch) begin
            col      <= '0;
            row      <= '0;
            stripe   <= '0;
            row_base <= base;
            cur_addr <= base;
        end else if (step) begin
            if (col == COL_LAST) begin
                // Rows are visited in increasing order across stripes, so one
                // running row base covers (stripe*P+row)*row_stride.
                col      <= '0;
                row_base <= row_base + row_stride;
                cur_addr <= row_base + row_stride;
                if (row == ROW_LAST) begin
                    row    <= '0;
                    stripe <= (stripe == STR_LAST) ? '0 : stripe + STR_W'(1);
                end else begin
                    row <= row + ROW_W'(1);
                end
            end else begin
                col      <= col + COL_W'(1);
                cur_addr <= cur_addr + ADDR_W'(1);
            end
        end
    end

    assign rd_addr = cur_addr;
    assign last    = (col == COL_LAST) && (row == ROW_LAST) && (stripe == STR_LAST);

endmodule

// File: rtl/pool_layer_sequencer.sv
// Sequences one pooling layer: per channel a datapath flush, an M*M read
// stream in stripe order, and a drain; done pulses after the last channel.
module pool_layer_sequencer
    import pool_seq_pkg::*;
#(
    parameter int M         = 4,
    parameter int P         = 2,
    parameter int N_CH      = 2,
    parameter int ADDR_W    = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic                      clk,
    input  logic                      master_rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [ADDR_W-1:0]         row_stride,
    input  logic [ADDR_W-1:0]         ch_stride,
    input  logic                      stall,
    output logic                      busy,
    output logic                      done,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    output logic                      pool_ce,
    output logic                      pool_rst_n,
    output logic [safe_w(N_CH)-1:0]   ch_idx
);

    localparam int CH_W    = safe_w(N_CH);
    localparam int DRAIN_W = safe_w(DRAIN_CYC + 1);
    localparam int FLUSH_W = safe_w(FLUSH_CYC);

    localparam logic [CH_W-1:0]    CH_LAST    = CH_W'(N_CH - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYC - 1);

    if (M % P != 0) begin : g_bad_geometry
        $error("pool_layer_sequencer: M must be a multiple of P");
    end

    state_t             state;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [ADDR_W-1:0]  ch_base;
    logic [ADDR_W-1:0]  row_stride_q;
    logic [ADDR_W-1:0]  ch_stride_q;
    logic [ADDR_W-1:0]  gen_addr;
    logic               gen_last;
    logic               gen_step;
    logic               gen_clear;

    assign gen_step  = (state == STREAM) && !stall;
    assign gen_clear = (state == FLUSH);

    pool_addr_gen #(
        .M      (M),
        .P      (P),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .master_rst (master_rst),
        .step       (gen_step),
        .clear_ch   (gen_clear),
        .base       (ch_base),
        .row_stride (row_stride_q),
        .rd_addr    (gen_addr),
        .last       (gen_last)
    );

    // Layer FSM with registered handshake, read strobe and datapath reset.
    always_ff @(posedge clk or posedge master_rst) begin
        if (master_rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            pool_rst_n   <= 1'b0;
            ch_idx       <= '0;
            flush_cnt    <= '0;
            drain_cnt    <= '0;
            ch_base      <= '0;
            row_stride_q <= '0;
            ch_stride_q  <= '0;
        end else begin
            rd_en      <= 1'b0;
            done       <= 1'b0;
            pool_rst_n <= 1'b1;
            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse is not a new request.
                    if (start && !done) begin
                        ch_base      <= base_addr;
                        row_stride_q <= row_stride;
                        ch_stride_q  <= ch_stride;
                        ch_idx       <= '0;
                        flush_cnt    <= '0;
                        busy         <= 1'b1;
                        state        <= FLUSH;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                FLUSH: begin
                    pool_rst_n <= 1'b0;
                    if (flush_cnt == FLUSH_LAST) begin
                        flush_cnt <= '0;
                        state     <= STREAM;
                    end else begin
                        flush_cnt <= flush_cnt + FLUSH_W'(1);
                    end
                end
                STREAM: begin
                    if (!stall) begin
                        rd_en   <= 1'b1;
                        rd_addr <= gen_addr;
                        if (gen_last) begin
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // First DRAIN cycle carries the final pool_ce; count from there.
                    if (drain_cnt == DRAIN_LAST) begin
                        drain_cnt <= '0;
                        if (ch_idx == CH_LAST) begin
                            state <= FIN;
                        end else begin
                            ch_idx    <= ch_idx + CH_W'(1);
                            ch_base   <= ch_base + ch_stride_q;
                            flush_cnt <= '0;
                            state     <= FLUSH;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data arrives one cycle after the strobe; ce marks it valid.
    always_ff @(posedge clk or posedge master_rst) begin
        if (master_rst) begin
            pool_ce <= 1'b0;
        end else begin
            pool_ce <= rd_en;
        end
    end

endmodule

// File: tb/tb_pool_layer_sequencer.sv
// Directed bench for pool_layer_sequencer with default parameters
// (M=4, P=2, N_CH=2, ADDR_W=16, DRAIN_CYC=3).
module tb_pool_layer_sequencer;

    logic        clk;
    logic        master_rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] row_stride;
    logic [15:0] ch_stride;
    logic        stall;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic        pool_ce;
    logic        pool_rst_n;
    logic [0:0]  ch_idx;

    pool_layer_sequencer dut (
        .clk        (clk),
        .master_rst (master_rst),
        .start      (start),
        .base_addr  (base_addr),
        .row_stride (row_stride),
        .ch_stride  (ch_stride),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .pool_ce    (pool_ce),
        .pool_rst_n (pool_rst_n),
        .ch_idx     (ch_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Per-run observations, all timed relative to the start-accept edge t0.
    int          t0 = 0;
    logic [15:0] addr_q[$];
    int          rd_rel_q[$];
    int          ce_cnt[2];
    int          rst_lo[2];
    int          done_cnt;
    int          done_rel;
    logic        busy_at_done;

    always @(negedge clk) begin
        if (rd_en) begin
            addr_q.push_back(rd_addr);
            rd_rel_q.push_back(cyc - t0);
        end
        if (pool_ce) ce_cnt[ch_idx] = ce_cnt[ch_idx] + 1;
        if (busy && !pool_rst_n) rst_lo[ch_idx] = rst_lo[ch_idx] + 1;
        if (done) begin
            done_cnt     = done_cnt + 1;
            done_rel     = cyc - t0;
            busy_at_done = busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        addr_q.delete();
        rd_rel_q.delete();
        ce_cnt[0]    = 0;
        ce_cnt[1]    = 0;
        rst_lo[0]    = 0;
        rst_lo[1]    = 0;
        done_cnt     = 0;
        done_rel     = -1;
        busy_at_done = 1'b0;
    endtask

    // Called at a negedge. Offset k: inputs set at cycle t0+k are sampled at edge t0+k+1.
    task automatic run_layer(input logic [15:0] b, input logic [15:0] rs, input logic [15:0] cs,
                             input int stall_from, input int stall_len,
                             input int pulse_a, input int pulse_b, input int n_cyc);
        clear_stats();
        base_addr  = b;
        row_stride = rs;
        ch_stride  = cs;
        start      = 1'b1;
        t0         = cyc + 1;
        for (int k = 0; k < n_cyc; k++) begin
            @(negedge clk);
            start = (k == pulse_a) || (k == pulse_b);
            stall = (k >= stall_from) && (k < stall_from + stall_len);
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic check_layer(input logic [15:0] b, input logic [15:0] rs, input logic [15:0] cs,
                               input int done_exp);
        int          idx;
        int          sum;
        logic [15:0] e;
        logic [15:0] o;
        check("rd_count", addr_q.size(), 32);
        for (int ch = 0; ch < 2; ch++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    idx = ch * 16 + r * 4 + c;
                    sum = int'(b) + ch * int'(cs) + r * int'(rs) + c;
                    e   = sum[15:0];
                    o   = (idx < addr_q.size()) ? addr_q[idx] : 16'hxxxx;
                    check($sformatf("addr[%0d]", idx), o, e);
                end
            end
        end
        check("ce_ch0", ce_cnt[0], 16);
        check("ce_ch1", ce_cnt[1], 16);
        check("flush_ch0", rst_lo[0], 2);
        check("flush_ch1", rst_lo[1], 2);
        check("done_cnt", done_cnt, 1);
        check("first_rd", (rd_rel_q.size() > 0) ? rd_rel_q[0] : -1, 3);
        check("done_time", done_rel, done_exp);
        check("busy_at_done", busy_at_done, 1'b1);
        check("busy_after", busy, 1'b0);
    endtask

    initial begin
        master_rst = 1'b1;
        start      = 1'b0;
        stall      = 1'b0;
        base_addr  = '0;
        row_stride = '0;
        ch_stride  = '0;
        clear_stats();

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_rd_addr", rd_addr, 16'h0000);
        check("rst_pool_ce", pool_ce, 1'b0);
        check("rst_pool_rst_n", pool_rst_n, 1'b0);
        check("rst_ch_idx", ch_idx, 1'b0);
        master_rst = 1'b0;
        @(negedge clk);
        check("rst_release_pool_rst_n", pool_rst_n, 1'b1);
        check("idle_busy", busy, 1'b0);
        @(negedge clk);

        // 1. Dense rows, no stall.
        run_layer(16'h0100, 16'd4, 16'h0010, -1, 0, -1, -1, 60);
        check_layer(16'h0100, 16'd4, 16'h0010, 45);

        // 2. Padded rows.
        run_layer(16'h0100, 16'd6, 16'h0010, -1, 0, -1, -1, 60);
        check_layer(16'h0100, 16'd6, 16'h0010, 45);
        check("pad_row1_first", addr_q[4], 16'h0106);
        check("pad_ch0_last", addr_q[15], 16'h0115);

        // 3. Stall for 3 cycles right after the 5th read.
        run_layer(16'h0100, 16'd4, 16'h0010, 7, 3, -1, -1, 60);
        check_layer(16'h0100, 16'd4, 16'h0010, 48);
        check("stall_rd5_time", rd_rel_q[4], 7);
        check("stall_rd6_time", rd_rel_q[5], 11);
        check("stall_resume_addr", addr_q[5], 16'h0105);

        // 4. Start pulsed mid-run and on the done cycle.
        run_layer(16'h0100, 16'd4, 16'h0010, -1, 0, 10, 45, 60);
        check_layer(16'h0100, 16'd4, 16'h0010, 45);

        // 5. Reset in the middle of channel 1's stream.
        run_layer(16'h0100, 16'd4, 16'h0010, -1, 0, -1, -1, 31);
        check("pre_rst_ch_idx", ch_idx, 1'b1);
        check("pre_rst_rd_en", rd_en, 1'b1);
        master_rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rd_en", rd_en, 1'b0);
        check("mid_rst_rd_addr", rd_addr, 16'h0000);
        check("mid_rst_pool_ce", pool_ce, 1'b0);
        check("mid_rst_pool_rst_n", pool_rst_n, 1'b0);
        check("mid_rst_ch_idx", ch_idx, 1'b0);
        repeat (20) @(negedge clk);
        check("mid_rst_no_done", done_cnt, 0);
        master_rst = 1'b0;
        repeat (2) @(negedge clk);
        run_layer(16'h0100, 16'd4, 16'h0010, -1, 0, -1, -1, 60);
        check_layer(16'h0100, 16'd4, 16'h0010, 45);

        // 6. Address wrap at the top of the address space.
        run_layer(16'hFFF8, 16'd4, 16'h0010, -1, 0, -1, -1, 60);
        check_layer(16'hFFF8, 16'd4, 16'h0010, 45);
        check("wrap_addr", addr_q[8], 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
